// File: rtl/mandelbrot_pixel_sink_if.sv
// rtl/mandelbrot_pixel_sink_if.sv - pixel stream bundle between the sink and its valid/ready consumer
interface mandelbrot_pixel_sink_if;
  logic [3:0] px_data;
  logic [9:0] px_x;
  logic [8:0] px_y;
  logic       px_sof;
  logic       px_eol;
  logic       px_valid;
  logic       px_ready;

  modport master (
    output px_data, px_x, px_y, px_sof, px_eol, px_valid,
    input  px_ready
  );

  modport slave (
    input  px_data, px_x, px_y, px_sof, px_eol, px_valid,
    output px_ready
  );
endinterface

// File: rtl/mandelbrot_pixel_sink.sv
// rtl/mandelbrot_pixel_sink.sv - frame sequencer, raster tagger and FIFO for the Mandelbrot count stream
// Optional frame CRC-8 over popped nibbles when MANDELBROT_PIXEL_SINK_CRC_EN is defined.
module mandelbrot_pixel_sink #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  output logic                           o_run,
  input  logic                           i_running,
  input  logic [3:0]                     i_ctr_in,
  input  logic                           i_new_ctr,
  mandelbrot_pixel_sink_if.master        px,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic                           o_overflow,
  output logic                           o_short_frame,
  output logic [7:0]                     o_crc
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int NPIX_I = WIDTH * HEIGHT;
  localparam int CNTW   = $clog2(NPIX_I + 1);
  localparam int XL_I   = WIDTH - 1;
  localparam int YL_I   = HEIGHT - 1;
  localparam logic [AW:0]      DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [CNTW-1:0]  NPIX    = NPIX_I[CNTW-1:0];
  localparam logic [9:0]       X_LAST  = XL_I[9:0];
  localparam logic [8:0]       Y_LAST  = YL_I[8:0];

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_RUN, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [24:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [9:0]        r_x;
  logic [8:0]        r_y;
  logic [CNTW-1:0]   r_pix_cnt;
  logic              r_overflow, r_short_frame;

  logic              w_pixel, w_empty, w_full, w_pop, w_push, w_drop;
  logic [CNTW-1:0]   w_cnt_nxt;
  logic [24:0]       w_entry;

  assign w_pixel   = (r_state == S_STREAM) && i_new_ctr;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = !w_empty && px.px_ready;
  // A full FIFO still takes the pixel when the head leaves in the same cycle.
  assign w_push    = w_pixel && (!w_full || w_pop);
  assign w_drop    = w_pixel && !w_push;
  assign w_cnt_nxt = (w_pixel && r_pix_cnt != NPIX) ? r_pix_cnt + 1'b1 : r_pix_cnt;
  assign w_entry   = {i_ctr_in, r_x, r_y, (r_x == '0) && (r_y == '0), r_x == X_LAST};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_state_nxt = S_ARM;
      S_ARM:      w_state_nxt = S_WAIT_RUN;
      S_WAIT_RUN: if (i_running) w_state_nxt = S_STREAM;
      S_STREAM:   if (!i_running) w_state_nxt = S_DRAIN;
      S_DRAIN:    if (w_empty) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_pix_cnt     <= '0;
      r_overflow    <= 1'b0;
      r_short_frame <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ARM) begin
        r_x           <= '0;
        r_y           <= '0;
        r_pix_cnt     <= '0;
        r_overflow    <= 1'b0;
        r_short_frame <= 1'b0;
      end else begin
        // Coordinates advance on dropped pixels too so later pixels stay correctly placed.
        if (w_pixel) begin
          r_pix_cnt <= w_cnt_nxt;
          if (r_x == X_LAST) begin
            r_x <= '0;
            if (r_y != Y_LAST) r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        if (w_drop) r_overflow <= 1'b1;
        if (r_state == S_STREAM && !i_running && w_cnt_nxt < NPIX) r_short_frame <= 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign {px.px_data, px.px_x, px.px_y, px.px_sof, px.px_eol} = r_mem[r_rd_ptr];
  assign px.px_valid    = !w_empty;
  assign o_run          = (r_state == S_ARM);
  assign o_busy         = (r_state != S_IDLE);
  assign o_frame_done   = (r_state == S_DONE);
  assign o_overflow     = r_overflow;
  assign o_short_frame  = r_short_frame;

`ifdef MANDELBROT_PIXEL_SINK_CRC_EN
  logic [7:0] r_crc;

  function automatic logic [7:0] crc8_nib(input logic [7:0] c, input logic [3:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 3; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 8'h00;
    end else if (r_state == S_ARM) begin
      r_crc <= 8'h00;
    end else if (w_pop) begin
      r_crc <= crc8_nib(r_crc, px.px_data);
    end
  end

  assign o_crc = r_crc;
`else
  assign o_crc = 8'h00;
`endif

endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// tb/tb_mandelbrot_pixel_sink.sv - randomized bench for mandelbrot_pixel_sink against a queue-based frame model
module tb_mandelbrot_pixel_sink;
  localparam int W = 4;
  localparam int H = 3;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       running = 1'b0;
  logic       new_ctr = 1'b0;
  logic [3:0] ctr = 4'h0;
  logic       run, busy, done, ovf, shrt;
  logic [7:0] crc;

  mandelbrot_pixel_sink_if pif ();

  mandelbrot_pixel_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .o_run(run), .i_running(running),
    .i_ctr_in(ctr), .i_new_ctr(new_ctr), .px(pif.master), .o_busy(busy),
    .o_frame_done(done), .o_overflow(ovf), .o_short_frame(shrt), .o_crc(crc)
  );

  always #5 clk = ~clk;

  logic [24:0] mq[$];
  int          k;
  bit          in_stream;
  bit          exp_ovf;
  logic [7:0]  exp_crc;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [3:0] d);
    logic [11:0] v;
    v = {c, 4'h0} ^ {d, 8'h00};
    for (int i = 11; i >= 8; i--) if (v[i]) v = v ^ (12'h107 << (i - 8));
    return v[7:0];
  endfunction

  task automatic cycle();
    bit          pop, can;
    int          x, y;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      k = 0; exp_ovf = 0; exp_crc = 8'h00;
    end else begin
      pop = (mq.size() > 0) && pif.px_ready;
      can = (mq.size() < D) || pop;
      if (pop) begin
        exp_crc = ref_crc(exp_crc, mq[0][24:21]);
        void'(mq.pop_front());
      end
      if (in_stream && new_ctr) begin
        x = k % W;
        y = (k / W < H) ? k / W : H - 1;
        if (can) mq.push_back({ctr, 10'(x), 9'(y), (x == 0 && y == 0), (x == W - 1)});
        else exp_ovf = 1;
        k++;
      end
    end
    #1;
    chk("px_valid", pif.px_valid, mq.size() != 0);
    if (pif.px_valid && mq.size() != 0)
      chk("px_payload", {pif.px_data, pif.px_x, pif.px_y, pif.px_sof, pif.px_eol}, mq[0]);
  endtask

  function automatic bit pick_ready(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return idx >= 6;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic run_frame(input int npix, input int rmode, input bit allf,
                           input bit coincide, input bit poke_start);
    bit seen;
    k = 0; exp_ovf = 0; exp_crc = 8'h00;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("run_pulse", run, 1);
    chk("busy_armed", busy, 1);
    cycle();
    chk("run_one_cycle", run, 0);
    running = 1'b1;
    cycle();
    in_stream = 1;
    for (int i = 0; i < npix; i++) begin
      new_ctr = 1'b1;
      ctr = allf ? 4'hF : 4'($urandom);
      running = !(coincide && i == npix - 1);
      pif.px_ready = pick_ready(rmode, i);
      start = poke_start ? 1'($urandom % 2) : 1'b0;
      cycle();
      chk("run_quiet", run, 0);
    end
    in_stream = 0;
    new_ctr = 1'b0;
    start = 1'b0;
    running = 1'b0;
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      pif.px_ready = pick_ready(rmode, 100);
      cycle();
      seen = done;
    end
    if (!seen) chk("frame_done_timeout", 0, 1);
    chk("overflow", ovf, exp_ovf);
    chk("short_frame", shrt, npix < W * H);
`ifdef MANDELBROT_PIXEL_SINK_CRC_EN
    chk("crc", crc, exp_crc);
`else
    chk("crc_zero", crc, 0);
`endif
    cycle();
    chk("frame_done_pulse", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    pif.px_ready = 1'b0;
    in_stream = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_run", run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", pif.px_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_short", shrt, 0);
    chk("rst_crc", crc, 0);
    cycle();
    rst_n = 1'b1;
    cycle();

    new_ctr = 1'b1;
    ctr = 4'h5;
    cycle();
    new_ctr = 1'b0;
    chk("idle_strobe_busy", busy, 0);

    run_frame(12, 0, 0, 0, 0);
    run_frame(12, 1, 0, 0, 0);
    run_frame(12, 2, 0, 1, 1);
    run_frame(7, 2, 0, 0, 0);

    k = 0; exp_ovf = 0; exp_crc = 8'h00;
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    running = 1'b1; cycle();
    in_stream = 1;
    pif.px_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      new_ctr = 1'b1; ctr = 4'($urandom);
      cycle();
    end
    chk("pre_rst_ovf", ovf, exp_ovf);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", pif.px_valid, 0);
    chk("async_rst_ovf", ovf, 0);
    chk("async_rst_short", shrt, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_run", run, 0);
    chk("async_rst_crc", crc, 0);
    in_stream = 0; new_ctr = 1'b0; running = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    run_frame(12, 2, 0, 0, 1);

    run_frame(12, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
